// File: rtl/sm_seq_divider.sv
// Sequential sign-magnitude restoring divider.
// One quotient bit per clock, MSB first; start/busy/done handshake.
// Magnitudes are WIDTH bits with separate sign bits. Results hold until the
// next DONE. A zero divisor completes in one cycle with div_zero set.
module sm_seq_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic             asign,
  input  logic [WIDTH-1:0] b,
  input  logic             bsign,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             sign,
  output logic [WIDTH-1:0] r,
  output logic             rsign,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_dvd;     // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] r_dvs;
  logic             r_asign;
  logic             r_bsign;
  logic [WIDTH:0]   r_rem;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] r_q;
  logic             r_sign;
  logic [WIDTH-1:0] r_r;
  logic             r_rsign;
  logic             r_dz;

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_q_fin;
  logic             w_last;

  // Trial subtraction for the current iteration.
  // The partial remainder is always below the divisor, so the shifted value
  // is below 2*divisor and the difference fits in WIDTH+1 bits.
  always_comb begin
    w_shift   = {r_rem, r_dvd[WIDTH-1]};
    w_qbit    = (w_shift >= {2'b00, r_dvs});
    w_diff    = w_shift[WIDTH:0] - {1'b0, r_dvs};
    w_rem_nxt = w_qbit ? w_diff : w_shift[WIDTH:0];
    w_q_fin   = {r_dvd[WIDTH-2:0], w_qbit};
    w_last    = (r_cnt == CW'(WIDTH - 1));
  end

  // Control state, operand capture and iteration datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_asign <= 1'b0;
      r_bsign <= 1'b0;
      r_rem   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd   <= a;
            r_dvs   <= b;
            r_asign <= asign;
            r_bsign <= bsign;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_state <= (b == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nxt;
          r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Result registers: written on entry to DONE, div_zero cleared on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= '0;
      r_sign  <= 1'b0;
      r_r     <= '0;
      r_rsign <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        if (b == '0) begin
          r_q     <= '1;
          r_r     <= a;
          r_sign  <= asign ^ bsign;
          r_rsign <= asign & (|a);
          r_dz    <= 1'b1;
        end else begin
          r_dz    <= 1'b0;
        end
      end else if (r_state == S_RUN && w_last) begin
        r_q     <= w_q_fin;
        r_r     <= w_rem_nxt[WIDTH-1:0];
        r_sign  <= (r_asign ^ r_bsign) & (|w_q_fin);
        r_rsign <= r_asign & (|w_rem_nxt[WIDTH-1:0]);
      end
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign q        = r_q;
  assign sign     = r_sign;
  assign r        = r_r;
  assign rsign    = r_rsign;
  assign div_zero = r_dz;

endmodule

// File: tb/tb_sm_seq_divider.sv
// Directed testbench for sm_seq_divider (WIDTH = 4).
module tb_sm_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic       asign = 1'b0;
  logic [3:0] b = '0;
  logic       bsign = 1'b0;
  logic       busy, done, sign, rsign, div_zero;
  logic [3:0] q, r;
  logic [10:0] res;

  int n_cmp = 0;
  int n_bad = 0;

  assign res = {q, sign, r, rsign, div_zero};

  always #5 clk = ~clk;

  sm_seq_divider #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .asign(asign), .b(b), .bsign(bsign),
    .busy(busy), .done(done), .q(q), .sign(sign),
    .r(r), .rsign(rsign), .div_zero(div_zero)
  );

  // Wait for IDLE, then pulse start for one edge; returns #1 after the start edge.
  task automatic launch(input logic [3:0] ia, input logic ias,
                        input logic [3:0] ib, input logic ibs);
    for (int i = 0; i < 50; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    a = ia; asign = ias; b = ib; bsign = ibs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // lat = 1 when done is visible right after the start edge; 0 means timeout.
  task automatic wait_done(output int lat, output int nbusy);
    lat = 0; nbusy = 0;
    for (int i = 1; i <= 40; i++) begin
      if (busy) nbusy++;
      if (done) begin lat = i; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, res} !== 13'b0) begin
      n_bad++; $display("FAIL reset_state: got %b expected %b", {busy, done, res}, 13'b0);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, res} !== 13'b0) begin
      n_bad++; $display("FAIL idle_after_reset: got %b expected %b", {busy, done, res}, 13'b0);
    end
  endtask

  task automatic test_basic;
    int lat, nb;
    launch(4'd9, 1'b0, 4'd2, 1'b0);
    wait_done(lat, nb);
    n_cmp++;
    if (lat !== 5) begin n_bad++; $display("FAIL basic_latency: got %0d expected 5", lat); end
    n_cmp++;
    if (nb !== 5) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d expected 5", nb); end
    n_cmp++;
    if (res !== {4'd4, 1'b0, 4'd1, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL basic_9div2: got %b expected %b", res, {4'd4, 1'b0, 4'd1, 1'b0, 1'b0});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done, res} !== {2'b00, 4'd4, 1'b0, 4'd1, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL basic_after_done: got %b expected %b", {busy, done, res},
                        {2'b00, 4'd4, 1'b0, 4'd1, 1'b0, 1'b0});
    end
  endtask

  task automatic test_signs;
    int lat, nb;
    launch(4'd9, 1'b1, 4'd2, 1'b0);
    wait_done(lat, nb);
    n_cmp++;
    if (res !== {4'd4, 1'b1, 4'd1, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL neg9div2: got %b expected %b", res, {4'd4, 1'b1, 4'd1, 1'b1, 1'b0});
    end
    launch(4'd8, 1'b1, 4'd2, 1'b1);
    wait_done(lat, nb);
    n_cmp++;
    if (res !== {4'd4, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL neg8divneg2: got %b expected %b", res, {4'd4, 1'b0, 4'd0, 1'b0, 1'b0});
    end
    launch(4'd3, 1'b0, 4'd5, 1'b1);
    wait_done(lat, nb);
    n_cmp++;
    if (res !== {4'd0, 1'b0, 4'd3, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL 3divneg5_zero_q: got %b expected %b", res, {4'd0, 1'b0, 4'd3, 1'b0, 1'b0});
    end
    launch(4'd15, 1'b1, 4'd1, 1'b0);
    wait_done(lat, nb);
    n_cmp++;
    if (res !== {4'd15, 1'b1, 4'd0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL neg15div1_zero_r: got %b expected %b", res, {4'd15, 1'b1, 4'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_div_zero;
    int lat, nb;
    launch(4'd7, 1'b1, 4'd0, 1'b0);
    wait_done(lat, nb);
    n_cmp++;
    if (lat !== 1) begin n_bad++; $display("FAIL dz_latency: got %0d expected 1", lat); end
    n_cmp++;
    if (res !== {4'd15, 1'b1, 4'd7, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL dz_result: got %b expected %b", res, {4'd15, 1'b1, 4'd7, 1'b1, 1'b1});
    end
    launch(4'd6, 1'b0, 4'd3, 1'b0);
    n_cmp++;
    if (res !== {4'd15, 1'b1, 4'd7, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL dz_clear_hold: got %b expected %b", res, {4'd15, 1'b1, 4'd7, 1'b1, 1'b0});
    end
    wait_done(lat, nb);
    n_cmp++;
    if (lat !== 5) begin n_bad++; $display("FAIL after_dz_latency: got %0d expected 5", lat); end
    n_cmp++;
    if (res !== {4'd2, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL after_dz_6div3: got %b expected %b", res, {4'd2, 1'b0, 4'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_ignore_start;
    int ndone = 0;
    int at = 0;
    launch(4'd13, 1'b1, 4'd3, 1'b0);
    a = 4'd2; b = 4'd1; asign = 1'b0; bsign = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++; at = i;
        n_cmp++;
        if (res !== {4'd4, 1'b1, 4'd1, 1'b1, 1'b0}) begin
          n_bad++; $display("FAIL ignore_result: got %b expected %b", res, {4'd4, 1'b1, 4'd1, 1'b1, 1'b0});
        end
      end
      if (i == 1) begin a = 4'd15; b = 4'd1; start = 1'b1; end
      if (i == 2) start = 1'b0;
      if (i == 4) begin a = 4'd5; b = 4'd5; start = 1'b1; end
      if (i == 5) start = 1'b0;
    end
    n_cmp++;
    if (ndone !== 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
    n_cmp++;
    if (at !== 4) begin n_bad++; $display("FAIL ignore_done_cycle: got %0d expected 4", at); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_no_restart: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    int ndone = 0;
    for (int i = 0; i < 50; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    a = 4'd6; asign = 1'b0; b = 4'd3; bsign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin a = 4'd14; b = 4'd4; end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          n_cmp++;
          if (i !== 4 || res !== {4'd2, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL b2b_first: got cycle %0d res %b expected cycle 4 res %b", i, res,
                              {4'd2, 1'b0, 4'd0, 1'b0, 1'b0});
          end
        end else begin
          n_cmp++;
          if (i !== 10 || res !== {4'd3, 1'b0, 4'd2, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL b2b_second: got cycle %0d res %b expected cycle 10 res %b", i, res,
                              {4'd3, 1'b0, 4'd2, 1'b0, 1'b0});
          end
        end
      end
      if (i == 10) start = 1'b0;
    end
    start = 1'b0;
    n_cmp++;
    if (ndone !== 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d expected 2", ndone); end
  endtask

  task automatic test_reset_mid;
    int lat, nb;
    int ndone = 0;
    launch(4'd9, 1'b0, 4'd2, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, res} !== 13'b0) begin
      n_bad++; $display("FAIL mid_reset_async: got %b expected %b", {busy, done, res}, 13'b0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    n_cmp++;
    if (ndone !== 0) begin n_bad++; $display("FAIL mid_reset_no_done: got %0d expected 0", ndone); end
    launch(4'd12, 1'b0, 4'd4, 1'b0);
    wait_done(lat, nb);
    n_cmp++;
    if (lat !== 5) begin n_bad++; $display("FAIL post_reset_latency: got %0d expected 5", lat); end
    n_cmp++;
    if (res !== {4'd3, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL post_reset_12div4: got %b expected %b", res, {4'd3, 1'b0, 4'd0, 1'b0, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
